// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decode handshake and redirect.
// fetch_misaligned exists only when MISALIGN_CHECK_EN is defined.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef MISALIGN_CHECK_EN
  logic        fetch_misaligned;

  modport master (
    output imem_req_valid, imem_addr, if_valid, if_instr, if_pc, fetch_misaligned,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input  imem_req_valid, imem_addr, if_valid, if_instr, if_pc, fetch_misaligned,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready, redirect_valid, redirect_pc
  );
`else
  modport master (
    output imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input  imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready, redirect_valid, redirect_pc
  );
`endif
endinterface

// File: rtl/fetch_unit.sv
// RISC-V fetch stage: PC, credit-limited word fetch, in-order response buffer, redirect with stale-drop.
// Optional misaligned-redirect trap is enabled by defining MISALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_SUM = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [31:0]   pc;
  logic [31:0]   rsp_pc;
  logic          misaligned;

  logic          credit_ok;
  logic          req_fire;
  logic          rsp_keep;
  logic          pop;
  logic [CW-1:0] out_next;
  logic [31:0]   target_pc;

  // Credits cover both buffered and in-flight words, so an accepted response always has a slot.
  assign credit_ok = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_SUM;

  assign bus.imem_req_valid = !reset && !bus.redirect_valid && !misaligned && credit_ok;
  assign bus.imem_addr      = pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign rsp_keep  = bus.imem_rsp_valid && (drop == '0) && !bus.redirect_valid;
  assign pop       = (count != '0) && bus.if_ready;
  assign out_next  = outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
  assign target_pc = {bus.redirect_pc[31:2], 2'b00};

  assign bus.if_valid = (count != '0);
  assign bus.if_instr = mem[head].instr;
  assign bus.if_pc    = mem[head].pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      // NOTE: the buffer is reset because its head entry drives if_instr/if_pc directly.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      outstanding <= out_next;
      if (bus.redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        pc     <= target_pc;
        rsp_pc <= target_pc;
        head   <= '0;
        tail   <= '0;
        count  <= '0;
        drop   <= out_next;
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (bus.imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
        if (rsp_keep) begin
          mem[tail] <= '{pc: rsp_pc, instr: bus.imem_rsp_data};
          tail      <= tail + PW'(1);
          rsp_pc    <= rsp_pc + 32'd4;
        end
        if (pop) head <= head + PW'(1);
        count <= count + CW'(rsp_keep) - CW'(pop);
      end
    end
  end

`ifdef MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      misaligned <= 1'b0;
    end else if (bus.redirect_valid) begin
      misaligned <= (bus.redirect_pc[1:0] != 2'b00);
    end
  end
  assign bus.fetch_misaligned = misaligned;
`else
  logic unused_redirect_lsbs;
  assign misaligned           = 1'b0;
  assign unused_redirect_lsbs = &{1'b0, bus.redirect_pc[1:0]};
`endif

  // Protocol and credit invariants, checked in simulation only.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(rsp_keep && (count == DEPTH_CNT)));
      assert (!(bus.imem_rsp_valid && (outstanding == '0)));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: instruction-memory model plus an in-order {pc, instr} scoreboard.
// Requests push expectations; decode pops are compared; redirects discard the old path.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } mrsp_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  mrsp_t       mem_q[$];
  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  int          lat    = 1;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge (scoreboard + memory model), then drive the response after posedge.
  task automatic tick();
    exp_t  e;
    mrsp_t r;
    @(negedge clk);
    if (!reset) begin
      if (bus.if_valid && bus.if_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL pop_unexpected: observed pc=0x%08h expected no instruction", bus.if_pc);
        end else begin
          e = exp_q.pop_front();
          check("if_pc", bus.if_pc, e.pc);
          check("if_instr", bus.if_instr, e.instr);
        end
      end
      if (bus.redirect_valid) begin
        check("req_during_redirect", {31'd0, bus.imem_req_valid}, 32'd0);
        exp_q.delete();
        req_log.delete();
      end else if (bus.imem_req_valid && bus.imem_req_ready) begin
        mem_q.push_back('{due: cyc + lat, data: instr_of(bus.imem_addr)});
        exp_q.push_back('{pc: bus.imem_addr, instr: instr_of(bus.imem_addr)});
        req_log.push_back(bus.imem_addr);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      r = mem_q.pop_front();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = r.data;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    tick();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    #1;
  endtask

  initial begin
    bit found;
    reset              = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.if_ready       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    repeat (3) tick();
    #1;
    check("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    check("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    check("rst_if_instr", bus.if_instr, 32'd0);
    check("rst_if_pc", bus.if_pc, 32'd0);
`ifdef MISALIGN_CHECK_EN
    check("rst_misaligned", {31'd0, bus.fetch_misaligned}, 32'd0);
`endif

    // Reset release: first request at RESET_PC, first instruction visible in the third cycle.
    reset = 1'b0;
    #1;
    check("first_addr", bus.imem_addr, 32'h0000_0100);
    check("first_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    check("c1_if_valid", {31'd0, bus.if_valid}, 32'd0);
    tick(); #1;
    check("c2_if_valid", {31'd0, bus.if_valid}, 32'd0);
    tick(); #1;
    check("c3_if_valid", {31'd0, bus.if_valid}, 32'd1);
    check("c3_if_pc", bus.if_pc, 32'h0000_0100);
    repeat (8) tick();
    check("seq_addr0", req_log[0], 32'h0000_0100);
    check("seq_addr1", req_log[1], 32'h0000_0104);
    check("seq_addr2", req_log[2], 32'h0000_0108);

    // Decode stall: credits bound the in-flight+buffered words and the head holds.
    bus.if_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      check("stall_credit", {31'd0, exp_q.size() <= 2}, 32'd1);
      if (bus.if_valid && exp_q.size() > 0) begin
        check("stall_head_pc", bus.if_pc, exp_q[0].pc);
        check("stall_head_instr", bus.if_instr, exp_q[0].instr);
      end
    end
    check("stall_full_valid", {31'd0, bus.if_valid}, 32'd1);
    check("stall_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    bus.if_ready = 1'b1;
    repeat (12) tick();

    // 3-cycle memory with two fetches in flight, then redirect: both stale words dropped.
    lat   = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (mem_q.size() == 2) found = 1'b1;
    end
    check("lat3_two_in_flight", {31'd0, found}, 32'd1);
    redirect(32'h0000_2000);
    check("redir_addr", bus.imem_addr, 32'h0000_2000);
    check("redir_flushed", {31'd0, bus.if_valid}, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(); #1;
      if (bus.if_valid) found = 1'b1;
    end
    check("redir_valid_seen", {31'd0, found}, 32'd1);
    check("redir_first_pc", bus.if_pc, 32'h0000_2000);
    check("redir_first_instr", bus.if_instr, instr_of(32'h0000_2000));
    repeat (10) tick();

    // Redirect colliding with a response and a pop.
    lat   = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(); #1;
      if (bus.imem_rsp_valid && bus.if_valid) found = 1'b1;
    end
    check("collide_found", {31'd0, found}, 32'd1);
    redirect(32'h0000_3000);
    check("collide_flushed", {31'd0, bus.if_valid}, 32'd0);
    check("collide_addr", bus.imem_addr, 32'h0000_3000);
    repeat (10) tick();
    check("collide_resume", req_log[0], 32'h0000_3000);

    // Address wrap at the top of the space.
    redirect(32'hFFFF_FFF8);
    repeat (10) tick();
    check("wrap_addr0", req_log[0], 32'hFFFF_FFF8);
    check("wrap_addr1", req_log[1], 32'hFFFF_FFFC);
    check("wrap_addr2", req_log[2], 32'h0000_0000);

`ifdef MISALIGN_CHECK_EN
    redirect(32'h0000_1002);
    check("mis_flag", {31'd0, bus.fetch_misaligned}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick(); #1;
      check("mis_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
      check("mis_no_valid", {31'd0, bus.if_valid}, 32'd0);
    end
    redirect(32'h0000_1004);
    check("mis_cleared", {31'd0, bus.fetch_misaligned}, 32'd0);
    check("mis_resume_addr", bus.imem_addr, 32'h0000_1004);
    check("mis_resume_req", {31'd0, bus.imem_req_valid}, 32'd1);
    repeat (8) tick();
    check("mis_resume_log", req_log[0], 32'h0000_1004);
`endif

    repeat (6) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
